// File: rtl/fdiv_iter_if.sv
// Handshake/data bundle for the iterative single-precision divider.
//   master: start, x1, x2 out; ready, valid, y, ovf, dvz in (requester side)
//   slave : the divider itself
interface fdiv_iter_if;
    logic        start;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        ready;
    logic        valid;
    logic [31:0] y;
    logic        ovf;
    logic        dvz;

    modport master (
        output start, x1, x2,
        input  ready, valid, y, ovf, dvz
    );

    modport slave (
        input  start, x1, x2,
        output ready, valid, y, ovf, dvz
    );
endinterface

// File: rtl/fdiv_iter.sv
// IEEE-754 single-precision divider y = x1 / x2, radix-2 restoring, fixed 28-cycle latency.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus.start  request, accepted when start && ready
//   bus.x1/x2  dividend/divisor, sampled at accept
//   bus.ready  high in IDLE and DONE
//   bus.valid  high in DONE; y/ovf/dvz held until next accept
//   bus.ovf    finite operands overflowed to infinity
//   bus.dvz    finite nonzero dividend divided by zero
module fdiv_iter #(
    parameter bit FLUSH_DENORM = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    fdiv_iter_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StNorm, StDiv, StRound, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       x1_q, x1_d, x2_q, x2_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [25:0]       rem_q, rem_d, quo_q, quo_d;
    logic [23:0]       dvs_q, dvs_d;
    logic signed [9:0] ez_q, ez_d;
    logic              sy_q, sy_d;
    logic              spec_q, spec_d, spec_dvz_q, spec_dvz_d;
    logic [31:0]       spec_y_q, spec_y_d;
    logic [31:0]       y_q, y_d;
    logic              ovf_q, ovf_d, dvz_q, dvz_d;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Operand unpack, normalization and special-case classification (used in NORM).
    logic [7:0]        e1, e2;
    logic [22:0]       f1, f2;
    logic              zero1, zero2, inf1, inf2, nan1, nan2, sy_w;
    logic [4:0]        lz1, lz2;
    logic [23:0]       m1n, m2n;
    logic signed [9:0] e1n, e2n, ez_norm;
    logic              spec_w, spec_dvz_w;
    logic [31:0]       spec_y_w;

    always_comb begin
        e1    = x1_q[30:23];
        e2    = x2_q[30:23];
        f1    = x1_q[22:0];
        f2    = x2_q[22:0];
        sy_w  = x1_q[31] ^ x2_q[31];
        zero1 = (e1 == 8'd0) && ((f1 == 23'd0) || FLUSH_DENORM);
        zero2 = (e2 == 8'd0) && ((f2 == 23'd0) || FLUSH_DENORM);
        inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
        inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
        nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
        nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
        // Denormals use exponent 1 with hidden bit 0, then shift the leading one up.
        lz1   = (e1 == 8'd0) ? lzc24({1'b0, f1}) : 5'd0;
        lz2   = (e2 == 8'd0) ? lzc24({1'b0, f2}) : 5'd0;
        m1n   = {(e1 != 8'd0), f1} << lz1;
        m2n   = {(e2 != 8'd0), f2} << lz2;
        e1n   = $signed({2'b00, ((e1 == 8'd0) ? 8'd1 : e1)}) - $signed({5'd0, lz1});
        e2n   = $signed({2'b00, ((e2 == 8'd0) ? 8'd1 : e2)}) - $signed({5'd0, lz2});
        ez_norm = e1n - e2n + 10'sd127;

        spec_w     = 1'b1;
        spec_dvz_w = 1'b0;
        spec_y_w   = 32'd0;
        if (nan2) begin
            spec_y_w = {x2_q[31], 8'hFF, 1'b1, f2[21:0]};
        end else if (nan1) begin
            spec_y_w = {x1_q[31], 8'hFF, 1'b1, f1[21:0]};
        end else if ((zero1 && zero2) || (inf1 && inf2)) begin
            spec_y_w = 32'h7FC0_0000;
        end else if (inf1) begin
            spec_y_w = {sy_w, 8'hFF, 23'd0};
        end else if (inf2) begin
            spec_y_w = {sy_w, 31'd0};
        end else if (zero2) begin
            spec_y_w   = {sy_w, 8'hFF, 23'd0};
            spec_dvz_w = 1'b1;
        end else if (zero1) begin
            spec_y_w = {sy_w, 31'd0};
        end else begin
            spec_w = 1'b0;
        end
    end

    // Normalize quotient, denormalize on underflow, round to nearest even (used in ROUND).
    logic [25:0]       qn, qs;
    logic signed [9:0] en, shamt;
    logic [4:0]        sh;
    logic              lost, stk, inc, big;
    logic [7:0]        ef;
    logic [30:0]       pre, rnd;
    logic [31:0]       round_y;
    logic              round_ovf;

    always_comb begin
        qn    = quo_q[25] ? quo_q : {quo_q[24:0], 1'b0};
        en    = quo_q[25] ? ez_q : (ez_q - 10'sd1);
        shamt = 10'sd1 - en;
        sh    = 5'd0;
        lost  = 1'b0;
        qs    = qn;
        ef    = 8'd0;
        if (en <= 10'sd0) begin
            sh   = (shamt > 10'sd26) ? 5'd26 : shamt[4:0];
            lost = |(qn & ~({26{1'b1}} << sh));
            qs   = qn >> sh;
        end else begin
            // Hidden bit in qs[25] adds the missing 1 back into the exponent field.
            ef = en[7:0] - 8'd1;
        end
        stk = (rem_q != 26'd0) | lost | qs[0];
        inc = qs[1] & (stk | qs[2]);
        pre = {ef, 23'd0} + {7'd0, qs[25:2]};
        // Carry out of the fraction ripples into the exponent (denormal -> min normal).
        rnd = pre + {30'd0, inc};
        big = (en >= 10'sd255) || (rnd[30:23] == 8'hFF);
        round_ovf = 1'b0;
        if (big) begin
            round_y   = {sy_q, 8'hFF, 23'd0};
            round_ovf = 1'b1;
        end else if (FLUSH_DENORM && (rnd[30:23] == 8'd0)) begin
            round_y = {sy_q, 31'd0};
        end else begin
            round_y = {sy_q, rnd};
        end
    end

    logic        ge;
    logic [25:0] rem_sub;

    always_comb begin
        state_d    = state_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        ez_d       = ez_q;
        sy_d       = sy_q;
        spec_d     = spec_q;
        spec_dvz_d = spec_dvz_q;
        spec_y_d   = spec_y_q;
        y_d        = y_q;
        ovf_d      = ovf_q;
        dvz_d      = dvz_q;
        ge         = rem_q >= {2'b00, dvs_q};
        rem_sub    = ge ? (rem_q - {2'b00, dvs_q}) : rem_q;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StNorm;
                    x1_d    = bus.x1;
                    x2_d    = bus.x2;
                end
            end
            StNorm: begin
                rem_d      = {2'b00, m1n};
                dvs_d      = m2n;
                quo_d      = 26'd0;
                cnt_d      = 5'd25;
                ez_d       = ez_norm;
                sy_d       = sy_w;
                spec_d     = spec_w;
                spec_dvz_d = spec_dvz_w;
                spec_y_d   = spec_y_w;
                state_d    = StDiv;
            end
            StDiv: begin
                rem_d = {rem_sub[24:0], 1'b0};
                quo_d = {quo_q[24:0], ge};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = StRound;
            end
            StRound: begin
                if (spec_q) begin
                    y_d   = spec_y_q;
                    ovf_d = 1'b0;
                    dvz_d = spec_dvz_q;
                end else begin
                    y_d   = round_y;
                    ovf_d = round_ovf;
                    dvz_d = 1'b0;
                end
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            x1_q       <= 32'd0;
            x2_q       <= 32'd0;
            cnt_q      <= 5'd0;
            rem_q      <= 26'd0;
            quo_q      <= 26'd0;
            dvs_q      <= 24'd0;
            ez_q       <= 10'sd0;
            sy_q       <= 1'b0;
            spec_q     <= 1'b0;
            spec_dvz_q <= 1'b0;
            spec_y_q   <= 32'd0;
            y_q        <= 32'd0;
            ovf_q      <= 1'b0;
            dvz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            ez_q       <= ez_d;
            sy_q       <= sy_d;
            spec_q     <= spec_d;
            spec_dvz_q <= spec_dvz_d;
            spec_y_q   <= spec_y_d;
            y_q        <= y_d;
            ovf_q      <= ovf_d;
            dvz_q      <= dvz_d;
        end
    end

    assign bus.ready = (state_q == StIdle) || (state_q == StDone);
    assign bus.valid = (state_q == StDone);
    assign bus.y     = y_q;
    assign bus.ovf   = ovf_q;
    assign bus.dvz   = dvz_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: two instances (full denormal / flush) driven in lockstep,
// compared against an exact integer-arithmetic model of IEEE-754 division.
module tb_fdiv_iter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fdiv_iter_if bus0 ();
    fdiv_iter_if bus1 ();

    fdiv_iter #(.FLUSH_DENORM(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fdiv_iter #(.FLUSH_DENORM(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    localparam int ND = 8;
    localparam logic [31:0] DA  [ND] = '{32'h40C00000, 32'h3F800000, 32'h7F000000, 32'h3F800000,
                                         32'h00000000, 32'h7FA00001, 32'h00800000, 32'h00000001};
    localparam logic [31:0] DB  [ND] = '{32'h40000000, 32'h40400000, 32'h3E800000, 32'h80000000,
                                         32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F000000};
    localparam logic [31:0] DY0 [ND] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'hFF800000,
                                         32'h7FC00000, 32'h7FE00001, 32'h00400000, 32'h00000002};
    localparam logic [31:0] DY1 [ND] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'hFF800000,
                                         32'h7FC00000, 32'h7FE00001, 32'h00000000, 32'h00000000};
    // {ovf, dvz}
    localparam logic [1:0]  DF  [ND] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

    function automatic int msb24(input logic [23:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 24; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Returns {ovf, dvz, y}. Finite case: value = sig * 2^p, quotient scaled to an integer
    // with LSB weight 2^lsb_w (at least 2^-149), rounded half-to-even with exact remainder.
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit flush);
        logic              sa, sb, sy;
        int                ea, eb, pa, pb, ma, mb, lg, lsb_w, sh, ebias;
        logic [22:0]       fa, fb;
        bit                nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        longint unsigned   sig_a, sig_b, num, den, qt, rm;
        sa = a[31]; sb = b[31]; sy = sa ^ sb;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0]; fb = b[22:0];
        nan_a  = (ea == 255) && (fa != 0);
        nan_b  = (eb == 255) && (fb != 0);
        inf_a  = (ea == 255) && (fa == 0);
        inf_b  = (eb == 255) && (fb == 0);
        zero_a = (ea == 0) && ((fa == 0) || flush);
        zero_b = (eb == 0) && ((fb == 0) || flush);
        if (nan_b) return {2'b00, sb, 8'hFF, 1'b1, fb[21:0]};
        if (nan_a) return {2'b00, sa, 8'hFF, 1'b1, fa[21:0]};
        if ((zero_a && zero_b) || (inf_a && inf_b)) return {2'b00, 32'h7FC00000};
        if (inf_a) return {2'b00, sy, 8'hFF, 23'd0};
        if (inf_b) return {2'b00, sy, 31'd0};
        if (zero_b) return {2'b01, sy, 8'hFF, 23'd0};
        if (zero_a) return {2'b00, sy, 31'd0};
        sig_a = (ea == 0) ? longint'(fa) : (longint'(fa) | 64'h800000);
        sig_b = (eb == 0) ? longint'(fb) : (longint'(fb) | 64'h800000);
        pa = (ea == 0) ? -149 : ea - 150;
        pb = (eb == 0) ? -149 : eb - 150;
        ma = msb24(sig_a[23:0]);
        mb = msb24(sig_b[23:0]);
        lg = ma - mb + pa - pb;
        if ((sig_a << (23 - ma)) < (sig_b << (23 - mb))) lg--;
        lsb_w = lg - 23;
        if (lsb_w < -149) lsb_w = -149;
        sh = pa - pb - lsb_w;
        if (sh >= 0) begin
            num = sig_a << sh; den = sig_b;
        end else if (sh > -38) begin
            num = sig_a; den = sig_b << (-sh);
        end else begin
            num = 0; den = 1;
        end
        qt = num / den;
        rm = num % den;
        if ((2 * rm > den) || ((2 * rm == den) && qt[0])) qt++;
        if (qt >= 64'h1000000) begin
            qt = qt >> 1;
            lsb_w++;
        end
        if (qt < 64'h800000) begin
            if (flush) return {2'b00, sy, 31'd0};
            return {2'b00, sy, 8'd0, qt[22:0]};
        end
        ebias = lsb_w + 150;
        if (ebias >= 255) return {2'b10, sy, 8'hFF, 23'd0};
        return {2'b00, sy, ebias[7:0], qt[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned c;
        logic [7:0]  e;
        logic [22:0] f;
        c = $urandom_range(0, 15);
        f = 23'($urandom);
        case (c)
            0:       begin e = 8'd0; f = 23'd0; end
            1, 2:    e = 8'd0;
            3:       begin e = 8'hFF; f = 23'd0; end
            4:       begin e = 8'hFF; f = f | 23'd1; end
            5, 6:    e = 8'($urandom_range(1, 20));
            7, 8:    e = 8'($urandom_range(230, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Issues one operation on both instances (caller guarantees ready) and waits for valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] y0, output logic [1:0] fl0,
                          output logic [31:0] y1, output logic [1:0] fl1,
                          output int lat, output logic v_after, output logic rdy_done,
                          output logic v1);
        @(negedge clk);
        bus0.start = 1'b1; bus0.x1 = a; bus0.x2 = b;
        bus1.start = 1'b1; bus1.x1 = a; bus1.x2 = b;
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        v_after = bus0.valid;
        lat = 0;
        while (!bus0.valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        y0 = bus0.y; fl0 = {bus0.ovf, bus0.dvz};
        y1 = bus1.y; fl1 = {bus1.ovf, bus1.dvz};
        rdy_done = bus0.ready;
        v1 = bus1.valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.start = 1'b0; bus0.x1 = 32'd0; bus0.x2 = 32'd0;
        bus1.start = 1'b0; bus1.x1 = 32'd0; bus1.x2 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.ready !== 1'b1 || bus1.ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b/%b want 1", bus0.ready, bus1.ready);
        end
        checks++;
        if (bus0.valid !== 1'b0 || bus1.valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b/%b want 0", bus0.valid, bus1.valid);
        end
        checks++;
        if (bus0.y !== 32'd0 || bus0.ovf !== 1'b0 || bus0.dvz !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got y=%h ovf=%b dvz=%b want 0", bus0.y, bus0.ovf,
                     bus0.dvz);
        end
    endtask

    task automatic test_directed();
        logic [31:0] y0, y1;
        logic [1:0]  f0, f1;
        logic        va, rd, v1;
        int          lat;
        for (int i = 0; i < ND; i++) begin
            run_op(DA[i], DB[i], y0, f0, y1, f1, lat, va, rd, v1);
            checks++;
            if (lat !== 28) begin
                errors++; $display("FAIL dir%0d_latency got %0d want 28", i, lat);
            end
            checks++;
            if (rd !== 1'b1 || v1 !== 1'b1) begin
                errors++; $display("FAIL dir%0d_ready_valid got ready=%b v1=%b want 1", i, rd, v1);
            end
            checks++;
            if (y0 !== DY0[i] || f0 !== DF[i]) begin
                errors++;
                $display("FAIL dir%0d %h/%h got y=%h fl=%b want y=%h fl=%b", i, DA[i], DB[i],
                         y0, f0, DY0[i], DF[i]);
            end
            checks++;
            if (y1 !== DY1[i] || f1 !== DF[i]) begin
                errors++;
                $display("FAIL dir%0d_flush %h/%h got y=%h fl=%b want y=%h fl=%b", i, DA[i],
                         DB[i], y1, f1, DY1[i], DF[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] y0, y1;
        logic [1:0]  f0, f1;
        logic        va, rd, v1, v_before;
        int          lat;
        run_op(32'h3F800000, 32'h40400000, y0, f0, y1, f1, lat, va, rd, v1);
        checks++;
        if (y0 !== 32'h3EAAAAAB) begin
            errors++; $display("FAIL b2b_first got %h want 3eaaaaab", y0);
        end
        v_before = bus0.valid;
        run_op(32'h3F800000, 32'h3F800000, y0, f0, y1, f1, lat, va, rd, v1);
        checks++;
        if (v_before !== 1'b1 || va !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid_drop got before=%b after=%b want 1/0", v_before, va);
        end
        checks++;
        if (lat !== 28 || y0 !== 32'h3F800000 || f0 !== 2'b00) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d y=%h fl=%b want 28 3f800000 00", lat, y0, f0);
        end
    endtask

    task automatic test_busy();
        int   lat;
        logic rdy_err;
        @(negedge clk);
        bus0.start = 1'b1; bus0.x1 = 32'h40C00000; bus0.x2 = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        bus0.x1 = 32'h3F800000; bus0.x2 = 32'h3F800000;
        lat = 0;
        rdy_err = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus0.ready !== 1'b0) rdy_err = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bus0.start = 1'b0;
        while (!bus0.valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (rdy_err) begin
            errors++; $display("FAIL busy_ready got 1 want 0 while busy");
        end
        checks++;
        if (lat !== 28 || bus0.y !== 32'h40400000) begin
            errors++;
            $display("FAIL busy_ignore got lat=%0d y=%h want 28 40400000", lat, bus0.y);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        bus0.start = 1'b1; bus0.x1 = 32'h40C00000; bus0.x2 = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus0.valid !== 1'b0 || bus0.y !== 32'd0 || bus0.ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid got valid=%b y=%h ready=%b want 0 0 1", bus0.valid, bus0.y,
                     bus0.ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus0.valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rst_mid_no_result got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, y0, y1;
        logic [1:0]  f0, f1;
        logic [33:0] e0, e1;
        logic        va, rd, v1;
        int          lat;
        for (int n = 0; n < 300; n++) begin
            a  = rand_fp();
            b  = rand_fp();
            e0 = ref_div(a, b, 1'b0);
            e1 = ref_div(a, b, 1'b1);
            run_op(a, b, y0, f0, y1, f1, lat, va, rd, v1);
            checks++;
            if (lat !== 28) begin
                errors++; $display("FAIL rnd_latency %h/%h got %0d want 28", a, b, lat);
            end
            checks++;
            if ({f0, y0} !== e0) begin
                errors++;
                $display("FAIL rnd %h/%h got fl=%b y=%h want fl=%b y=%h", a, b, f0, y0,
                         e0[33:32], e0[31:0]);
            end
            checks++;
            if ({f1, y1} !== e1) begin
                errors++;
                $display("FAIL rnd_flush %h/%h got fl=%b y=%h want fl=%b y=%h", a, b, f1, y1,
                         e1[33:32], e1[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
